// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register: 2-entry skid buffer with valid/ready handshakes,
// synchronous flush and a saturating back-pressure counter.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // State bits are {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_main_valid;
    logic             w_skid_valid;
    logic             w_accept;
    logic             w_fire;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign w_main_valid = r_state[1];
    assign w_skid_valid = r_state[0];
    assign w_accept     = in_valid & in_ready;
    assign w_fire       = out_valid & out_ready;

    // in_ready comes straight from a flop so no combinational path from out_ready.
    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_next = S_ONE;
                S_ONE: begin
                    if (w_accept && !w_fire) begin
                        w_next = S_FULL;
                    end else if (!w_accept && w_fire) begin
                        w_next = S_EMPTY;
                    end
                end
                S_FULL:  if (w_fire) w_next = S_ONE;
                default: w_next = S_EMPTY;
            endcase
        end
    end

    // Datapath load strobes; flush suppresses every write except the clear.
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_load_main_in = w_accept;
                S_ONE: begin
                    w_load_main_in = w_accept & w_fire;
                    w_load_skid    = w_accept & ~w_fire;
                end
                S_FULL:  w_load_main_skid = w_fire;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
            end
        end
    end

    // Back-pressure profiling counter; deliberately ignores flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: expected payloads queued at issue, popped by a
// monitor on every downstream transfer; a CNT_W=3 copy checks counter saturation.
module tb_pipe_skid_reg;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_cnt;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    pipe_skid_reg #(.WIDTH(32), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.WIDTH(32), .CNT_W(3)) dut_sat (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .flush(flush), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nRST = 1'b0;
        drive(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);

        // Monitor: every downstream transfer must match the oldest queued payload.
        fork
            forever begin
                @(negedge CLK);
                if (nRST && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", out_data, 32'hxxxx_xxxx);
                    end else begin
                        chk("sb_out_data", out_data, exp_q.pop_front());
                    end
                end
            end
        join_none

        // Reset release with in_valid already high
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        exp_q.push_back(32'hA5A5_A5A5);
        @(posedge CLK);
        #1;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("first_out_valid", 32'(out_valid), 32'd1);
        chk("first_out_data", out_data, 32'hA5A5_A5A5);
        step();
        chk("first_drained_occ", 32'(occupancy), 32'd0);

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b0);
            exp_q.push_back(32'(i));
            if (i > 1) begin
                chk("stream_occ", 32'(occupancy), 32'd1);
                chk("stream_data", out_data, 32'(i - 1));
            end
            step();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("stream_last", out_data, 32'd4);
        step();
        chk("stream_empty", 32'(occupancy), 32'd0);
        chk("stream_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure: 1 and 2 absorbed, 3 held upstream
        drive(1'b1, 32'd1, 1'b0, 1'b0);
        chk("bp_ready0", 32'(in_ready), 32'd1);
        exp_q.push_back(32'd1);
        step();
        drive(1'b1, 32'd2, 1'b0, 1'b0);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        chk("bp_occ1", 32'(occupancy), 32'd1);
        exp_q.push_back(32'd2);
        step();
        drive(1'b1, 32'd3, 1'b0, 1'b0);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_occ_full", 32'(occupancy), 32'd2);
        exp_q.push_back(32'd3);
        step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_out_head", out_data, 32'd1);
        step();
        drive(1'b1, 32'd3, 1'b1, 1'b0);
        step();
        chk("bp_drain_ready", 32'(in_ready), 32'd1);
        chk("bp_drain_data", out_data, 32'd2);
        step();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("bp_drain_last", out_data, 32'd3);
        step();
        chk("bp_empty", 32'(occupancy), 32'd0);
        chk("bp_stall", 32'(stall_cnt), 32'd3);

        // Flush in FULL with a simultaneous in_valid carrying 9
        drive(1'b1, 32'd10, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'd11, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'd9, 1'b0, 1'b1);
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        step();
        exp_q.delete();
        drive(1'b1, 32'd12, 1'b0, 1'b0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_out_data", out_data, 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_stall", 32'(stall_cnt), 32'd5);
        exp_q.push_back(32'd12);
        step();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("fl_next_data", out_data, 32'd12);
        step();
        chk("fl_next_empty", 32'(occupancy), 32'd0);

        // Stall counter saturation on the CNT_W=3 instance
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        step();
        drive(1'b1, 32'd20, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("sat_small", 32'(s_stall_cnt), (k > 7) ? 32'd7 : 32'(k));
            chk("sat_big", 32'(stall_cnt), 32'(k));
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("sat_after_flush", 32'(s_stall_cnt), 32'd7);
        chk("sat_flush_valid", 32'(s_out_valid), 32'd0);

        // Asynchronous reset while FULL
        drive(1'b1, 32'd30, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'd31, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("ar_pre_occ", 32'(occupancy), 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_stall", 32'(stall_cnt), 32'd0);
        chk("ar_stall_small", 32'(s_stall_cnt), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 32'd40, 1'b0, 1'b0);
        exp_q.push_back(32'd40);
        step();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("ar_post_valid", 32'(out_valid), 32'd1);
        chk("ar_post_data", out_data, 32'd40);
        chk("ar_post_occ", 32'(occupancy), 32'd1);
        step();
        chk("ar_post_empty", 32'(occupancy), 32'd0);
        chk("ar_post_stall", 32'(stall_cnt), 32'd0);

        step();
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
